// File: rtl/otter_pkg.sv
// Shared OTTER definitions used by the fetch stage: next-PC select codes,
// fetch-state encoding, the canonical NOP and the default reset PC.
package otter_pkg;

    typedef enum logic [2:0] {
        PCSRC_PC4    = 3'd0,
        PCSRC_JALR   = 3'd1,
        PCSRC_BRANCH = 3'd2,
        PCSRC_JAL    = 3'd3,
        PCSRC_MTVEC  = 3'd4,
        PCSRC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select for the fetch stage. With FETCH_MISALIGN_TRAP_EN
// a misaligned redirect target is replaced by mtvec and reported.
module pc_next_mux
    import otter_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  pc_source,
    input  logic        hold,
    input  logic [31:0] jalr_tgt,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] pc_next,
    output logic        redirect,
    output logic        misalign,
    output logic [31:0] misalign_tgt
);

    logic [31:0] target_s;

    // Decode the redirect source; reserved codes fall through as sequential fetch.
    always_comb begin
        redirect = 1'b1;
        target_s = pc;
        case (pc_source)
            PCSRC_JALR:   target_s = jalr_tgt;
            PCSRC_BRANCH: target_s = branch_tgt;
            PCSRC_JAL:    target_s = jal_tgt;
            PCSRC_MTVEC:  target_s = mtvec;
            PCSRC_MEPC:   target_s = mepc;
            default:      redirect = 1'b0;
        endcase
    end

    // Pick the next fetch address; a redirect always wins over hold.
    always_comb begin
        pc_next      = pc;
        misalign     = 1'b0;
        misalign_tgt = 32'h0000_0000;
        if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (is_misaligned(target_s)) begin
                pc_next      = word_align(mtvec);
                misalign     = 1'b1;
                misalign_tgt = target_s;
            end else begin
                pc_next = target_s;
            end
`else
            pc_next = word_align(target_s);
`endif
        end else if (hold) begin
            pc_next = pc;
        end else begin
            pc_next = pc + 32'd4;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// OTTER instruction-fetch stage: PC register, synchronous imem interface and IF/ID
// register. Optional misaligned-target trap via macro FETCH_MISALIGN_TRAP_EN.
module pc_fetch_stage
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  PC_source,
    input  logic [31:0] jalr_tgt,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic        imem_rden,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_ir,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] misalign_addr
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  ifid_pc_r;
    logic [31:0]  ifid_pc4_r;
    logic [31:0]  ifid_ir_r;
    logic         ifid_valid_r;
    logic         misalign_err_r;
    logic [31:0]  misalign_addr_r;

    logic [31:0]  mux_pc_next_s;
    logic [31:0]  pc_next_s;
    logic         redirect_s;
    logic         misalign_s;
    logic [31:0]  misalign_tgt_s;
    logic         hold_s;
    logic [31:0]  pc_plus4_s;

    // Outside RUN the word at pc is re-read rather than advanced past, so it is
    // captured on the first RUN edge.
    assign hold_s     = stall | (state_r != FS_RUN);
    assign pc_plus4_s = pc_r + 32'd4;

    pc_next_mux u_pc_next_mux (
        .pc           (pc_r),
        .pc_source    (PC_source),
        .hold         (hold_s),
        .jalr_tgt     (jalr_tgt),
        .branch_tgt   (branch_tgt),
        .jal_tgt      (jal_tgt),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .pc_next      (mux_pc_next_s),
        .redirect     (redirect_s),
        .misalign     (misalign_s),
        .misalign_tgt (misalign_tgt_s)
    );

    // Reset forces the fetch address so the first word is ready after release.
    always_comb begin
        if (!RST_N) begin
            pc_next_s = RESET_PC;
        end else begin
            pc_next_s = mux_pc_next_s;
        end
    end

    assign imem_addr = pc_next_s;
    assign imem_rden = ~RST_N | redirect_s | ~stall;

    // PC, fetch state machine, IF/ID register and misalignment report.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_r            <= RESET_PC;
            state_r         <= FS_BOOT;
            ifid_pc_r       <= 32'h0000_0000;
            ifid_pc4_r      <= 32'h0000_0000;
            ifid_ir_r       <= NOP_INSTR;
            ifid_valid_r    <= 1'b0;
            misalign_err_r  <= 1'b0;
            misalign_addr_r <= 32'h0000_0000;
        end else begin
            pc_r           <= pc_next_s;
            misalign_err_r <= misalign_s;
            if (misalign_s) begin
                misalign_addr_r <= misalign_tgt_s;
            end
            if (redirect_s) begin
                state_r      <= FS_FLUSH;
                ifid_ir_r    <= NOP_INSTR;
                ifid_valid_r <= 1'b0;
            end else if (!stall) begin
                case (state_r)
                    FS_RUN: begin
                        state_r      <= FS_RUN;
                        ifid_pc_r    <= pc_r;
                        ifid_pc4_r   <= pc_plus4_s;
                        ifid_ir_r    <= imem_data;
                        ifid_valid_r <= 1'b1;
                    end
                    FS_BOOT, FS_FLUSH: begin
                        state_r      <= FS_RUN;
                        ifid_ir_r    <= NOP_INSTR;
                        ifid_valid_r <= 1'b0;
                    end
                    default: begin
                        state_r      <= FS_BOOT;
                        ifid_ir_r    <= NOP_INSTR;
                        ifid_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ifid_pc       = ifid_pc_r;
    assign ifid_pc4      = ifid_pc4_r;
    assign ifid_ir       = ifid_ir_r;
    assign ifid_valid    = ifid_valid_r;
    assign misalign_err  = misalign_err_r;
    assign misalign_addr = misalign_addr_r;

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low.
REQ-004 PC_source  input  3  next-PC select from branch condition generator; 0=PC+4, 1=JALR, 2=BRANCH, 3=JAL, 4=MTVEC, 5=MEPC, 6/7 reserved.
REQ-005 jalr_tgt, branch_tgt, jal_tgt  input  32 each  EX-stage targets.
REQ-006 mtvec, mepc  input  32 each  CSR trap-vector and return addresses.
REQ-007 stall  input  1  hazard-unit hold of IF and IF/ID.
REQ-008 imem_addr  output  32  instruction memory read address.
REQ-009 imem_rden  output  1  instruction memory read enable.
REQ-010 imem_data  input  32  synchronous read data, valid the cycle after imem_rden with the address then presented.
REQ-011 ifid_pc, ifid_pc4, ifid_ir  output  32 each  IF/ID register: PC, PC+4, instruction.
REQ-012 ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-013 misalign_err, misalign_addr  output  1, 32  misaligned-target report (REQ-027 only).

Function
REQ-014 pc_next: PC_source!=0 selects the matching target; PC_source==0 and !stall selects pc+4; stall and PC_source==0 selects pc.
REQ-015 Reserved PC_source 6/7 SHALL be treated as 0.
REQ-016 imem_addr SHALL equal pc_next combinationally; imem_rden SHALL be 1 unless stall with PC_source==0.
REQ-017 pc SHALL load pc_next each cycle, so imem_data is the word at pc.
REQ-018 State machine BOOT/RUN/FLUSH: BOOT at reset; BOOT->RUN next cycle; RUN->FLUSH on PC_source!=0; FLUSH->RUN next cycle, or stays FLUSH on another redirect.
REQ-019 RUN, !stall, no redirect: IF/ID SHALL capture {pc, pc+4, imem_data}, ifid_valid=1.
REQ-020 BOOT or FLUSH: imem_data is not trusted; IF/ID SHALL load a bubble (ifid_valid=0, ifid_ir=32'h0000_0013 NOP).
REQ-021 Redirect (PC_source!=0): IF/ID SHALL load a bubble the same edge; redirect SHALL override stall.
REQ-022 stall without redirect: pc, IF/ID and state SHALL hold; the held memory output is reused after release.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-024 Redirect-to-first-valid latency: target instruction SHALL appear in IF/ID 2 edges after the redirect edge.

Reset
REQ-025 RST_N=0 at an edge SHALL set pc=RESET_PC, state=BOOT, ifid_pc=ifid_pc4=0, ifid_ir=NOP, ifid_valid=0, misalign_err=0, misalign_addr=0; this overrides stall and redirect.
REQ-026 During reset, imem_addr=RESET_PC, imem_rden=1, so the first word is valid on the cycle after reset release.

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect target with bits[1:0]!=0 is not loaded; pc_next=mtvec, misalign_err pulses 1 cycle, misalign_addr=offending target. Undefined: target bits[1:0] forced to 00, misalign_err and misalign_addr tied 0.

Structure
REQ-028 Shared package otter_pkg SHALL hold the PC_source enum (PCSRC_PC4..PCSRC_MEPC), fetch-state enum, NOP constant and RESET_PC default.
REQ-029 One sub-module, pc_next_mux (combinational target select), is natural; the rest stays in pc_fetch_stage.

Verification
REQ-030 Reset release, memory returns 0x00A00093 at 0: cycle 1 ifid_valid=0; cycle 2 ifid_pc=0, ifid_ir=0x00A00093, valid=1.
REQ-031 Straight-line, 4 cycles: ifid_pc 0,4,8,C consecutive; ifid_pc4=ifid_pc+4.
REQ-032 PC_source=2, branch_tgt=0x100 at pc=0x10: next ifid bubble, following cycle ifid_pc=0x100 valid.
REQ-033 stall 3 cycles at pc=0x20, PC_source=0: IF/ID and imem_rden=0 hold, then ifid_pc=0x20 with correct IR.
REQ-034 stall=1 with PC_source=3, jal_tgt=0x200 same cycle: redirect taken, bubble, then ifid_pc=0x200.
REQ-035 Macro defined, PC_source=1, jalr_tgt=0x102, mtvec=0x80: misalign_err=1 one cycle, misalign_addr=0x102, fetch resumes at 0x80; undefined: fetch resumes at 0x100.
